dac_sample_feeder: RTL

- Rate-paced sample buffer directly upstream of the DACx811 SPI serializer.
- Accepts samples on a valid/ready stream into a DEPTH-entry FIFO.
- Issues one `dac_start`/`dac_data` transfer to the serializer every RATE_DIV clocks.
- Reports FIFO level, underruns and late ticks so firmware can size its writes.

---
 rtl/dac_sample_feeder.sv | 115 +++++++++++
 1 files changed

// File: rtl/dac_sample_feeder.sv
// Rate-paced sample FIFO feeding the DACx811 serializer: one dac_start every RATE_DIV clocks, start is registered (tick+1).
// s_ready = ~full (0 in reset). Define FEEDER_HOLD_LAST_EN to re-issue the last sample on underrun.
module dac_sample_feeder #(
  parameter int BITS     = 16,
  parameter int DEPTH    = 8,
  parameter int RATE_DIV = 100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       clr_stat,
  input  logic                       s_valid,
  input  logic [BITS-1:0]            s_data,
  output logic                       s_ready,
  output logic                       dac_start,
  output logic [BITS-1:0]            dac_data,
  input  logic                       dac_busy,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic [15:0]                underruns,
  output logic                       late
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam int CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;

  state_t          state, state_nxt;
  logic [BITS-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   cnt;
  logic            tick, push, pop, issue, full, empty, under_evt, late_evt;

  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign s_ready = ~full & ~rst;
  assign push    = s_valid & s_ready;
  assign tick    = en & (cnt == CW'(RATE_DIV - 1));

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    issue     = 1'b0;
    under_evt = 1'b0;
    late_evt  = 1'b0;
    case (state)
      IDLE: begin
        if (tick) begin
          if (!empty) begin
            pop       = 1'b1;
            issue     = 1'b1;
            state_nxt = WAIT_HI;
          end else begin
            under_evt = 1'b1;
`ifdef FEEDER_HOLD_LAST_EN
            issue     = 1'b1;
            state_nxt = WAIT_HI;
`endif
          end
        end
      end
      // Busy is registered in the serializer, so it lags dac_start by a cycle.
      WAIT_HI: begin
        late_evt = tick;
        if (dac_busy) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        late_evt = tick;
        if (!dac_busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      dac_start <= 1'b0;
      dac_data  <= '0;
      underruns <= '0;
      late      <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= (!en || tick) ? '0 : cnt + 1'b1;
      dac_start <= issue;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr   <= rd_ptr + 1'b1;
        dac_data <= mem[rd_ptr];
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      if (clr_stat) begin
        underruns <= '0;
        late      <= 1'b0;
      end else begin
        if (under_evt && underruns != 16'hFFFF) underruns <= underruns + 16'd1;
        if (late_evt) late <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

endmodule
